// File: rtl/isa_dma_pkg.sv
// isa_dma_pkg: shared types for the ISA DMA arbiter.
// FSM states, channel count, direction encodings.
package isa_dma_pkg;

  localparam int NUM_CH = 4;

  localparam logic DIR_IOR = 1'b0;
  localparam logic DIR_IOW = 1'b1;

  typedef logic [1:0] chan_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_FETCH,
    S_BUSREQ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/dma_drq_sync.sv
// dma_drq_sync: multi-flop synchroniser for the raw DRQ lines.
// Every bit is independent; all flops clear on reset.
module dma_drq_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  // shift the raw inputs through STAGES flops
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/isa_dma_arbiter.sv
// isa_dma_arbiter: four-channel single-mode ISA DMA arbiter/sequencer.
// Define DMA_ROUND_ROBIN_EN for rotating priority (default: ch0 highest).
module isa_dma_arbiter
  import isa_dma_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int LEN_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic [3:0]        drq,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_chan,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_dir,
  output logic              cfg_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              wr_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        xfer_chan,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic              aen,
  output logic [3:0]        dack_n,
  output logic              ior_n,
  output logic              iow_n,
  output logic [3:0]        tc
);

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);

  state_t              state;
  logic [7:0]          cyc;
  logic [LEN_W-1:0]    count [NUM_CH];
  logic [NUM_CH-1:0]   dir_q;
  logic [NUM_CH-1:0]   drq_s;
  logic [NUM_CH-1:0]   pending;
  chan_t               winner;
  logic                found;
  logic                cfg_hit;
  logic                xdir;
`ifdef DMA_ROUND_ROBIN_EN
  chan_t               last;
`endif

  dma_drq_sync #(
    .WIDTH  (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .d         (drq),
    .q         (drq_s)
  );

  // a channel competes only while it requests and has work left
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pending[i] = drq_s[i] && (count[i] != '0);
    end
  end

  // pick the winner among pending channels
  always_comb begin
    chan_t idx;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef DMA_ROUND_ROBIN_EN
      idx = last + chan_t'(i) + 2'd1;
`else
      idx = chan_t'(i);
`endif
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // config writes to the channel being (or about to be) served are refused
  always_comb begin
    cfg_hit = 1'b0;
    if (cfg_wr) begin
      if (state == S_ARB) begin
        cfg_hit = found && (cfg_chan == winner);
      end else if (state != S_IDLE) begin
        cfg_hit = (cfg_chan == xfer_chan);
      end
    end
  end

  assign xdir = dir_q[xfer_chan];

  // sequencer FSM with registered bus outputs and per-channel counts
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cyc       <= '0;
      dir_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
      end
      cfg_err   <= 1'b0;
      bus_req   <= 1'b0;
      wr_req    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      xfer_chan <= '0;
      d_out     <= '0;
      d_oe      <= 1'b0;
      aen       <= 1'b0;
      dack_n    <= 4'hF;
      ior_n     <= 1'b1;
      iow_n     <= 1'b1;
      tc        <= '0;
`ifdef DMA_ROUND_ROBIN_EN
      last      <= chan_t'(NUM_CH - 1);
`endif
    end else begin
      rd_valid <= 1'b0;
      tc       <= '0;
      cfg_err  <= cfg_hit;
      if (cfg_wr && !cfg_hit) begin
        count[cfg_chan] <= cfg_len;
        dir_q[cfg_chan] <= cfg_dir;
      end
      unique case (state)
        S_IDLE: begin
          if (|pending) state <= S_ARB;
        end
        S_ARB: begin
          if (found) begin
            xfer_chan <= winner;
`ifdef DMA_ROUND_ROBIN_EN
            last      <= winner;
`endif
            if (dir_q[winner] == DIR_IOW) begin
              wr_req <= 1'b1;
              state  <= S_FETCH;
            end else begin
              bus_req <= 1'b1;
              state   <= S_BUSREQ;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (wr_valid) begin
            d_out   <= wr_data;
            wr_req  <= 1'b0;
            bus_req <= 1'b1;
            state   <= S_BUSREQ;
          end
        end
        S_BUSREQ: begin
          if (bus_gnt) begin
            aen               <= 1'b1;
            dack_n[xfer_chan] <= 1'b0;
            d_oe              <= (xdir == DIR_IOW);
            cyc               <= SETUP_LAST;
            state             <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cyc == '0) begin
            if (xdir == DIR_IOW) iow_n <= 1'b0;
            else                 ior_n <= 1'b0;
            cyc   <= STROBE_LAST;
            state <= S_STROBE;
          end else begin
            cyc <= cyc - 8'd1;
          end
        end
        S_STROBE: begin
          if (cyc == '0) begin
            ior_n <= 1'b1;
            iow_n <= 1'b1;
            if (xdir == DIR_IOR) begin
              rd_data  <= d_in;
              rd_valid <= 1'b1;
            end
            state <= S_HOLD;
          end else begin
            cyc <= cyc - 8'd1;
          end
        end
        S_HOLD: begin
          dack_n  <= 4'hF;
          aen     <= 1'b0;
          d_oe    <= 1'b0;
          bus_req <= 1'b0;
          count[xfer_chan] <= count[xfer_chan] - LEN_W'(1);
          if (count[xfer_chan] == LEN_W'(1)) tc[xfer_chan] <= 1'b1;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_dma_arbiter.sv
// tb_isa_dma_arbiter: directed bench for isa_dma_arbiter.
// Negedge monitor accumulates bus activity; checks compare totals.
`timescale 1ns/1ps
module tb_isa_dma_arbiter;

  logic        sys_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic [3:0]  drq       = 4'hF;
  logic        cfg_wr    = 1'b0;
  logic [1:0]  cfg_chan  = '0;
  logic [15:0] cfg_len   = '0;
  logic        cfg_dir   = 1'b0;
  logic        cfg_err;
  logic        bus_req;
  logic        bus_gnt   = 1'b1;
  logic        wr_req;
  logic        wr_valid  = 1'b0;
  logic [15:0] wr_data   = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [1:0]  xfer_chan;
  logic [15:0] d_in      = '0;
  logic [15:0] d_out;
  logic        d_oe;
  logic        aen;
  logic [3:0]  dack_n;
  logic        ior_n;
  logic        iow_n;
  logic [3:0]  tc;

  int checks = 0;
  int errors = 0;

  isa_dma_arbiter dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .drq       (drq),
    .cfg_wr    (cfg_wr),
    .cfg_chan  (cfg_chan),
    .cfg_len   (cfg_len),
    .cfg_dir   (cfg_dir),
    .cfg_err   (cfg_err),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .wr_req    (wr_req),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .xfer_chan (xfer_chan),
    .d_in      (d_in),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .aen       (aen),
    .dack_n    (dack_n),
    .ior_n     (ior_n),
    .iow_n     (iow_n),
    .tc        (tc)
  );

  always #100 sys_clock = ~sys_clock;

  logic        mon_clr = 1'b0;
  int          cyc_n = 0;
  int          n_ior, n_iow, n_rdv, n_tc, n_wrreq;
  int          n_oe, n_aen, n_breq, n_cerr, n_bad;
  int          rise_t, gap;
  logic [3:0]  tc_acc, dack_seen;
  logic [23:0] ord;
  logic [15:0] iow_data;
  logic        aen_q = 1'b0;
  logic [3:0]  dack_q = 4'hF;

  function automatic logic [3:0] enc(input logic [3:0] d);
    logic [3:0] r;
    r = 4'hF;
    case (d)
      4'b1110: r = 4'd0;
      4'b1101: r = 4'd1;
      4'b1011: r = 4'd2;
      4'b0111: r = 4'd3;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  always @(negedge sys_clock) begin
    if (mon_clr) begin
      n_ior = 0; n_iow = 0; n_rdv = 0; n_tc = 0; n_wrreq = 0;
      n_oe = 0; n_aen = 0; n_breq = 0; n_cerr = 0; n_bad = 0;
      rise_t = 0; gap = 0; tc_acc = '0; dack_seen = '0;
      ord = '0; iow_data = '0;
    end else begin
      cyc_n++;
      if (!ior_n) n_ior++;
      if (!iow_n) begin
        n_iow++;
        iow_data = d_out;
      end
      if (rd_valid) n_rdv++;
      if (tc != 4'h0) n_tc++;
      tc_acc = tc_acc | tc;
      if (wr_req) n_wrreq++;
      if (d_oe) n_oe++;
      if (aen) n_aen++;
      if (bus_req) n_breq++;
      if (cfg_err) n_cerr++;
      if (!ior_n && !iow_n) n_bad++;
      if (aen && !bus_gnt) n_bad++;
      if (dack_n != 4'hF && !aen) n_bad++;
      dack_seen = dack_seen | ~dack_n;
      if (aen && !aen_q) begin
        gap = cyc_n - rise_t;
        rise_t = cyc_n;
      end
      if (dack_n != 4'hF && dack_q == 4'hF) ord = {ord[19:0], enc(dack_n)};
    end
    aen_q = aen;
    dack_q = dack_n;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sys_clock);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    wait_n(1);
    mon_clr = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] len,
                     input logic dir);
    cfg_wr   = 1'b1;
    cfg_chan = ch;
    cfg_len  = len;
    cfg_dir  = dir;
    wait_n(1);
    cfg_wr   = 1'b0;
  endtask

  initial begin
    int k;
    clear_mon();
    // 1: reset values, no requests while all channels are disabled
    wait_n(2);
    check("rst_dack", dack_n, 4'hF);
    check("rst_strb", {ior_n, iow_n}, 2'b11);
    check("rst_aen_oe", {aen, d_oe, bus_req, wr_req}, 4'h0);
    reset_n = 1'b1;
    wait_n(20);
    check("idle_breq", n_breq, 0);
    check("idle_out", {rd_valid, tc, cfg_err, xfer_chan}, 8'h0);
    check("idle_data", {rd_data, d_out}, 32'h0);

    // 2: IOR channel 1, two transfers
    drq = 4'h0;
    d_in = 16'hA55A;
    wait_n(3);
    clear_mon();
    cfg(2'd1, 16'd2, 1'b0);
    drq = 4'b0010;
    k = 0;
    while (n_tc < 1 && k < 300) begin wait_n(1); k++; end
    drq = 4'h0;
    wait_n(4);
    check("t2_ior_cyc", n_ior, 6);
    check("t2_rdv", n_rdv, 2);
    check("t2_rdata", rd_data, 16'hA55A);
    check("t2_tc", {28'h0, tc_acc}, 4'b0010);
    check("t2_ntc", n_tc, 1);
    check("t2_dack", {28'h0, dack_seen}, 4'b0010);
    check("t2_gap", gap, 9);
    check("t2_oe_bad", {n_oe, n_bad}, 0);

    // 3: IOW channel 3, write data arrives late
    clear_mon();
    cfg(2'd3, 16'd1, 1'b1);
    drq = 4'b1000;
    k = 0;
    while (!wr_req && k < 200) begin wait_n(1); k++; end
    check("t3_wrreq_up", wr_req, 1'b1);
    wait_n(3);
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    wait_n(1);
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    k = 0;
    while (n_tc < 1 && k < 300) begin wait_n(1); k++; end
    drq = 4'h0;
    wait_n(4);
    check("t3_wrreq_cyc", n_wrreq, 4);
    check("t3_iow_cyc", {n_iow, n_ior}, {32'd3, 32'd0});
    check("t3_dout", iow_data, 16'h1234);
    check("t3_oe_cyc", n_oe, 5);
    check("t3_tc", {28'h0, tc_acc}, 4'b1000);
    check("t3_rdv_bad", {n_rdv, n_bad}, 0);

    // 4: ch0 and ch2 competing, three transfers each
    clear_mon();
    cfg(2'd0, 16'd3, 1'b0);
    cfg(2'd2, 16'd3, 1'b0);
    drq = 4'b0101;
    k = 0;
    while (n_tc < 2 && k < 600) begin wait_n(1); k++; end
    drq = 4'h0;
    wait_n(4);
`ifdef DMA_ROUND_ROBIN_EN
    check("t4_order", {8'h0, ord}, 24'h020202);
`else
    check("t4_order", {8'h0, ord}, 24'h000222);
`endif
    check("t4_tc", {28'h0, tc_acc}, 4'b0101);

    // 5: bus grant withheld
    clear_mon();
    bus_gnt = 1'b0;
    cfg(2'd2, 16'd1, 1'b0);
    drq = 4'b0100;
    k = 0;
    while (!bus_req && k < 100) begin wait_n(1); k++; end
    wait_n(10);
    check("t5_hold", {bus_req, aen, dack_n}, 6'b10_1111);
    check("t5_aen_cyc", n_aen, 0);
    bus_gnt = 1'b1;
    k = 0;
    while (n_tc < 1 && k < 300) begin wait_n(1); k++; end
    drq = 4'h0;
    wait_n(4);
    check("t5_ior_cyc", n_ior, 3);
    check("t5_tc_bad", {tc_acc, n_bad[3:0]}, 8'h40);

    // 6a: config write to the active channel mid-strobe is refused
    clear_mon();
    d_in = 16'h5A5A;
    cfg(2'd1, 16'd2, 1'b0);
    drq = 4'b0010;
    k = 0;
    while (ior_n !== 1'b0 && k < 200) begin wait_n(1); k++; end
    check("t6_strobe", ior_n, 1'b0);
    cfg(2'd1, 16'd7, 1'b0);
    k = 0;
    while (n_tc < 1 && k < 300) begin wait_n(1); k++; end
    wait_n(4);
    check("t6_cerr", n_cerr, 1);
    check("t6_rdv_tc", {n_rdv, n_tc}, {32'd2, 32'd1});
    check("t6_rdata", rd_data, 16'h5A5A);

    // 6b: reset asserted during strobe
    cfg(2'd1, 16'd1, 1'b0);
    k = 0;
    while (ior_n !== 1'b0 && k < 200) begin wait_n(1); k++; end
    check("t6_strobe2", ior_n, 1'b0);
    @(posedge sys_clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_out", {ior_n, iow_n, dack_n, aen, bus_req}, 8'b11_1111_00);
    drq = 4'h0;
    clear_mon();
    wait_n(3);
    reset_n = 1'b1;
    wait_n(20);
    check("t6_no_rdv", {n_rdv, n_breq}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
